busif_n: RTL and testbench



---
 rtl/busif_n.sv | 154 +++++++++++++++
 tb/tb_busif_n.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/busif_n.sv
// busif_n: decodes the MicroBlaze MCS IO bus into BANKS peripheral banks with per-bank ready wait.
// Define BUSIF_TIMEOUT_EN to abort hung wait-bank accesses after TIMEOUT cycles and flag BUSERR.
module busif_n #(
  parameter int          BANKS     = 8,
  parameter int          BANK_LSB  = 28,
  parameter logic [15:0] WAIT_MASK = 16'h0001,
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IO_Addr_Strobe,
  input  logic                       IO_Read_Strobe,
  input  logic                       IO_Write_Strobe,
  input  logic [31:0]                IO_Address,
  output logic [31:0]                IO_Read_Data,
  output logic                       IO_Ready,
  output logic [BANKS-1:0]           WR,
  output logic [BANKS-1:0]           RD,
  input  logic [32*BANKS-1:0]        RDATA,
  input  logic [BANKS-1:0]           BANK_RDY,
  output logic                       BUSERR,
  output logic [$clog2(BANKS)-1:0]   ERR_BANK
);
  localparam int BW = $clog2(BANKS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic [BANKS-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             buserr_q, buserr_d;
  logic [BW-1:0]    err_bank_q, err_bank_d;
  logic [BW-1:0]    new_bank_s;
  logic [BANKS-1:0] new_oh_s, sel_oh_s;
  logic             wait_s, rdy_s, expire_s;
  logic [31:0]      bank_data_s;
  logic             unused_s;

  assign new_bank_s  = IO_Address[BANK_LSB +: BW];
  assign new_oh_s    = {{(BANKS-1){1'b0}}, 1'b1} << new_bank_s;
  assign sel_oh_s    = {{(BANKS-1){1'b0}}, 1'b1} << bank_q;
  assign wait_s      = |(WAIT_MASK[BANKS-1:0] & sel_oh_s);
  assign rdy_s       = |(BANK_RDY & sel_oh_s);
  assign bank_data_s = RDATA[{bank_q, 5'd0} +: 32];
  // Read qualifier is implied (a non-write access is a read); address bits outside the bank field are don't-care.
  assign unused_s    = ^{IO_Read_Strobe, IO_Address, ERR_DATA, TIMEOUT[0]};

`ifdef BUSIF_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_s = (cnt_q == CW'(TIMEOUT - 1));

  // Access-time counter: zero outside ACC, so it restarts on every entry.
  always_comb begin
    if (state_q == S_ACC) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Access FSM: strobe launches a bank pulse, completion captures data and raises IO_Ready.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    wr_d       = {BANKS{1'b0}};
    rd_d       = {BANKS{1'b0}};
    buserr_d   = buserr_q;
    err_bank_d = err_bank_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (IO_Addr_Strobe) begin
          state_d = S_ACC;
          bank_d  = new_bank_s;
          if (IO_Write_Strobe) begin
            wr_d = new_oh_s;
          end else begin
            rd_d = new_oh_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        // Ready beats expiry when both land on the same edge.
        if (!wait_s || rdy_s) begin
          state_d = S_DONE;
          rdata_d = bank_data_s;
          ready_d = 1'b1;
        end else if (expire_s) begin
          state_d    = S_DONE;
          rdata_d    = ERR_DATA;
          ready_d    = 1'b1;
          buserr_d   = 1'b1;
          err_bank_d = bank_q;
        end else begin
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      bank_q     <= {BW{1'b0}};
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      wr_q       <= {BANKS{1'b0}};
      rd_q       <= {BANKS{1'b0}};
      buserr_q   <= 1'b0;
      err_bank_q <= {BW{1'b0}};
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      buserr_q   <= buserr_d;
      err_bank_q <= err_bank_d;
    end
  end

  assign IO_Read_Data = rdata_q;
  assign IO_Ready     = ready_q;
  assign WR           = wr_q;
  assign RD           = rd_q;
  assign BUSERR       = buserr_q;
  assign ERR_BANK     = err_bank_q;
endmodule

// File: tb/tb_busif_n.sv
// tb_busif_n: scoreboard bench for busif_n; expected completions are queued at launch and
// matched (data and cycle) when IO_Ready fires. Timeout checks run only with BUSIF_TIMEOUT_EN.
module tb_busif_n;
  localparam int BANKS = 8;

  logic                 clk = 1'b0;
  logic                 RST = 1'b1;
  logic                 IO_Addr_Strobe = 1'b0;
  logic                 IO_Read_Strobe = 1'b0;
  logic                 IO_Write_Strobe = 1'b0;
  logic [31:0]          IO_Address = 32'd0;
  logic [31:0]          IO_Read_Data;
  logic                 IO_Ready;
  logic [BANKS-1:0]     WR, RD;
  logic [32*BANKS-1:0]  RDATA = '0;
  logic [BANKS-1:0]     BANK_RDY = '0;
  logic                 BUSERR;
  logic [2:0]           ERR_BANK;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   err_cnt = 0;

  busif_n #(.TIMEOUT(16)) dut (
    .CLK(clk), .RST(RST),
    .IO_Addr_Strobe(IO_Addr_Strobe), .IO_Read_Strobe(IO_Read_Strobe),
    .IO_Write_Strobe(IO_Write_Strobe), .IO_Address(IO_Address),
    .IO_Read_Data(IO_Read_Data), .IO_Ready(IO_Ready),
    .WR(WR), .RD(RD), .RDATA(RDATA), .BANK_RDY(BANK_RDY),
    .BUSERR(BUSERR), .ERR_BANK(ERR_BANK)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Completion monitor: every IO_Ready must match the oldest queued expectation.
  always @(negedge clk) begin
    if (IO_Ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_ready", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rdata", IO_Read_Data, mon_e.data);
        check_eq("ready_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Drive a one-cycle strobe sampled at edge 0; returns during cycle 1. lat=0 queues nothing.
  task automatic start(input logic [31:0] addr, input logic wr, input logic [31:0] exp_data, input int lat);
    exp_t x;
    @(posedge clk); #1;
    IO_Addr_Strobe  = 1'b1;
    IO_Write_Strobe = wr;
    IO_Read_Strobe  = ~wr;
    IO_Address      = addr;
    @(posedge clk); #1;
    IO_Addr_Strobe  = 1'b0;
    IO_Write_Strobe = 1'b0;
    IO_Read_Strobe  = 1'b0;
    if (lat > 0) begin
      x.data = exp_data;
      x.cyc  = cyc + lat - 1;
      exp_q.push_back(x);
    end
  endtask

  task automatic check_pulse(input string tag, input logic [7:0] wr_exp, input logic [7:0] rd_exp);
    @(negedge clk);
    check_eq({tag, "_wr"}, WR, wr_exp);
    check_eq({tag, "_rd"}, RD, rd_exp);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("wait_bound", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_ready"}, IO_Ready, 32'd0);
    check_eq({tag, "_wr"}, WR, 32'd0);
    check_eq({tag, "_rd"}, RD, 32'd0);
    check_eq({tag, "_rdata"}, IO_Read_Data, 32'd0);
    check_eq({tag, "_buserr"}, BUSERR, 32'd0);
    check_eq({tag, "_errbank"}, ERR_BANK, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  initial begin
    RDATA[32*0 +: 32] = 32'h0000_A5A5;
    RDATA[32*2 +: 32] = 32'h2222_2222;
    RDATA[32*3 +: 32] = 32'h3333_3333;
    RDATA[32*5 +: 32] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    check_idle_outputs("reset");

    // Fixed-latency write to bank 2.
    start(32'h2000_0010, 1'b1, 32'h2222_2222, 2);
    check_pulse("wr_b2_c1", 8'h04, 8'h00);
    check_pulse("wr_b2_c2", 8'h00, 8'h00);
    wait_done(10);

    // Fixed-latency read from bank 5.
    start(32'h5000_0000, 1'b0, 32'h1234_5678, 2);
    check_pulse("rd_b5_c1", 8'h00, 8'h20);
    check_pulse("rd_b5_c2", 8'h00, 8'h00);
    wait_done(10);

    // Wait bank 0: other-bank ready pulsed early, own ready raised in cycle 6.
    start(32'h0000_0000, 1'b0, 32'h0000_A5A5, 7);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      BANK_RDY[1] = (k == 1 || k == 2);
      BANK_RDY[0] = (k == 5);
    end
    @(posedge clk); #1;
    BANK_RDY = '0;
    wait_done(20);

    // Wait bank 0 with ready already high in the pulse cycle.
    RDATA[32*0 +: 32] = 32'h0F0F_1E1E;
    BANK_RDY[0] = 1'b1;
    start(32'h0000_0004, 1'b0, 32'h0F0F_1E1E, 2);
    check_pulse("rd_b0_c1", 8'h00, 8'h01);
    @(posedge clk); #1;
    BANK_RDY = '0;
    wait_done(10);

    // Back-to-back: second strobe lands in the DONE cycle of the first.
    RDATA[32*5 +: 32] = 32'h0BAD_F00D;
    start(32'h3000_0000, 1'b1, 32'h3333_3333, 2);
    start(32'h5000_0000, 1'b0, 32'h0BAD_F00D, 2);
    check_pulse("b2b_c1", 8'h00, 8'h20);
    check_pulse("b2b_c2", 8'h00, 8'h00);
    wait_done(10);

`ifdef BUSIF_TIMEOUT_EN
    // Hung bank 0 read aborts after TIMEOUT cycles.
    start(32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 17);
    wait_done(40);
    @(negedge clk);
    check_eq("to_buserr", BUSERR, 32'd1);
    check_eq("to_errbank", ERR_BANK, 32'd0);
    start(32'h3000_0000, 1'b0, 32'h3333_3333, 2);
    wait_done(10);
    @(negedge clk);
    check_eq("to_buserr_sticky", BUSERR, 32'd1);
`else
    @(negedge clk);
    check_eq("buserr_tied", BUSERR, 32'd0);
    check_eq("errbank_tied", ERR_BANK, 32'd0);
`endif

    // Reset in cycle 3 of a pending wait-bank access: no completion, clean outputs.
    start(32'h0000_0000, 1'b0, 32'd0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    RST = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    RST = 1'b0;
    check_idle_outputs("mid_rst");
    repeat (4) @(posedge clk);
    start(32'h2000_0000, 1'b0, 32'h2222_2222, 2);
    check_pulse("post_rst_c1", 8'h00, 8'h04);
    wait_done(10);
    @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
